riscv_hart: RTL and testbench

RISCV_HART -- requirements
Module: riscv_hart

---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/riscv_alu.sv | 41 ++++
 rtl/riscv_hart.sv | 173 +++++++++++++++++
 tb/tb_riscv_hart.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, instruction layout and ALU operation set for the hart.
package riscv_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  localparam logic [2:0] FUNCT3_LW   = 3'b010;
  localparam logic [2:0] FUNCT3_SW   = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      FUNCT3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      FUNCT3_SLL:  return ALU_SLL;
      FUNCT3_SLT:  return ALU_SLT;
      FUNCT3_SLTU: return ALU_SLTU;
      FUNCT3_XOR:  return ALU_XOR;
      FUNCT3_SR:   return alt ? ALU_SRA : ALU_SRL;
      FUNCT3_OR:   return ALU_OR;
      default:     return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU: result for the selected op plus equality/signed/unsigned compare flags.
module riscv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = XLEN'(lt);
      ALU_SLTU:   result = XLEN'(ltu);
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = XLEN'($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_hart.sv
// Three-stage RV32I hart (EX -> MEM -> WB) with external 1-cycle fetch, no forwarding or interlock.
module riscv_hart
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  instruction_t    instruction,
  output logic [AW-1:0]   pc,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_read
);

  logic [XLEN-1:0] regs [32];
  logic [AW-1:0]   ex_pc;
  logic            ex_valid;
  logic            mem_we, mem_load, wb_we, wb_load;
  logic [4:0]      mem_rd, wb_rd;
  logic [XLEN-1:0] mem_result, wb_result, wb_value;

  logic [XLEN-1:0] rs1_val, rs2_val, pc_x;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] op_a, op_b, alu_result, target, ex_result;
  alu_op_t         alu_op;
  logic            cmp_eq, cmp_lt, cmp_ltu;
  logic            rd_we, is_load, is_store, is_link, take;

  assign wb_value = wb_load ? mem_read : wb_result;

  // WB write is visible to the EX read in the same cycle
  assign rs1_val = (instruction.rs1 == 5'd0) ? '0 :
                   (wb_we && wb_rd == instruction.rs1) ? wb_value : regs[instruction.rs1];
  assign rs2_val = (instruction.rs2 == 5'd0) ? '0 :
                   (wb_we && wb_rd == instruction.rs2) ? wb_value : regs[instruction.rs2];

  assign pc_x  = XLEN'(ex_pc);
  assign imm_i = XLEN'($signed({instruction.funct7, instruction.rs2}));
  assign imm_s = XLEN'($signed({instruction.funct7, instruction.rd}));
  assign imm_b = XLEN'($signed({instruction.funct7[6], instruction.rd[0], instruction.funct7[5:0],
                                instruction.rd[4:1], 1'b0}));
  assign imm_u = XLEN'($signed({instruction.funct7, instruction.rs2, instruction.rs1,
                                instruction.funct3, 12'b0}));
  assign imm_j = XLEN'($signed({instruction.funct7[6], instruction.rs1, instruction.funct3,
                                instruction.rs2[0], instruction.funct7[5:0], instruction.rs2[4:1], 1'b0}));

  always_comb begin
    op_a     = rs1_val;
    op_b     = imm_i;
    alu_op   = ALU_ADD;
    rd_we    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_link  = 1'b0;
    take     = 1'b0;
    target   = pc_x + imm_b;
    case (instruction.opcode)
      OP_IMM: begin
        alu_op = alu_op_of(instruction.funct3,
                           instruction.funct7[5] && instruction.funct3 == FUNCT3_SR);
        rd_we  = 1'b1;
      end
      OP: begin
        op_b   = rs2_val;
        alu_op = alu_op_of(instruction.funct3, instruction.funct7[5]);
        rd_we  = 1'b1;
      end
      OP_LUI: begin
        op_b   = imm_u;
        alu_op = ALU_PASS_B;
        rd_we  = 1'b1;
      end
      OP_AUIPC: begin
        op_a  = pc_x;
        op_b  = imm_u;
        rd_we = 1'b1;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        is_link = 1'b1;
        take    = 1'b1;
        target  = pc_x + imm_j;
      end
      OP_JALR: begin
        rd_we     = 1'b1;
        is_link   = 1'b1;
        take      = 1'b1;
        target    = rs1_val + imm_i;
        target[0] = 1'b0;
      end
      OP_BRANCH: begin
        op_b = rs2_val;
        case (instruction.funct3)
          FUNCT3_BEQ:  take = cmp_eq;
          FUNCT3_BNE:  take = !cmp_eq;
          FUNCT3_BLT:  take = cmp_lt;
          FUNCT3_BGE:  take = !cmp_lt;
          FUNCT3_BLTU: take = cmp_ltu;
          FUNCT3_BGEU: take = !cmp_ltu;
          default:     take = 1'b0;
        endcase
      end
      OP_LOAD: begin
        rd_we   = (instruction.funct3 == FUNCT3_LW);
        is_load = (instruction.funct3 == FUNCT3_LW);
      end
      OP_STORE: begin
        op_b     = imm_s;
        is_store = (instruction.funct3 == FUNCT3_SW);
      end
      default: ;
    endcase
    ex_result = is_link ? pc_x + XLEN'(4) : alu_result;
  end

  riscv_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_result),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .ltu    (cmp_ltu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= '0;
      ex_pc      <= '0;
      ex_valid   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      mem_load   <= 1'b0;
      mem_rd     <= '0;
      mem_result <= '0;
      wb_we      <= 1'b0;
      wb_load    <= 1'b0;
      wb_rd      <= '0;
      wb_result  <= '0;
    end else begin
      ex_pc <= pc;
      // a taken redirect squashes the instruction already fetched behind it
      if (ex_valid && take) begin
        pc       <= AW'(target);
        ex_valid <= 1'b0;
      end else begin
        pc       <= pc + AW'(4);
        ex_valid <= 1'b1;
      end
      mem_write  <= ex_valid && is_store;
      mem_addr   <= AW'(alu_result);
      mem_data   <= rs2_val;
      mem_we     <= ex_valid && rd_we;
      mem_load   <= is_load;
      mem_rd     <= instruction.rd;
      mem_result <= ex_result;
      wb_we      <= mem_we;
      wb_load    <= mem_load;
      wb_rd      <= mem_rd;
      wb_result  <= mem_result;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_we && wb_rd != 5'd0) regs[wb_rd] <= wb_value;
  end

endmodule

// File: tb/tb_riscv_hart.sv
// Bench for riscv_hart: directed programs plus random hazard-free programs checked against an ISA-level model.
module tb_riscv_hart;
  import riscv_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  instruction_t instruction;
  logic [31:0]  pc, mem_addr, mem_data, mem_read;
  logic         mem_write;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] dmem_init [64];
  logic [31:0] mdm [64];
  logic        mem_init = 1'b0;

  int checks = 0;
  int errors = 0;

  riscv_hart #(.XLEN(32), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    instruction <= imem[pc[9:2]];
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dmem_init[i];
    end else if (mem_write) begin
      dmem[mem_addr[7:2]] <= mem_data;
    end
    mem_read <= dmem[mem_addr[7:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm);
    return {imm[31:12], rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Sequential ISA interpreter over imem/dmem_init; result memory image lands in mdm.
  task automatic run_model(input int plen);
    logic [31:0] r [32];
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, val, npc, p, addr;
    logic [2:0]  f3;
    logic        wr, tk;
    int          steps;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int i = 0; i < 64; i++) mdm[i] = dmem_init[i];
    p = 32'd0;
    steps = 0;
    while (p < 32'(plen * 4) && steps < 1000) begin
      ins = imem[p[9:2]];
      a = r[ins[19:15]];
      b = r[ins[24:20]];
      f3 = ins[14:12];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {ins[31:12], 12'b0};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      npc = p + 32'd4;
      wr = 1'b0;
      val = 32'd0;
      case (ins[6:0])
        OP_IMM:   begin wr = 1'b1; val = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
        OP:       begin wr = 1'b1; val = ref_alu(f3, ins[30], a, b); end
        OP_LUI:   begin wr = 1'b1; val = iu; end
        OP_AUIPC: begin wr = 1'b1; val = p + iu; end
        OP_JAL:   begin wr = 1'b1; val = p + 32'd4; npc = p + ij; end
        OP_JALR:  begin wr = 1'b1; val = p + 32'd4; npc = (a + ii) & ~32'd1; end
        OP_BRANCH: begin
          case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
          endcase
          if (tk) npc = p + ib;
        end
        OP_LOAD: if (f3 == 3'd2) begin
          addr = a + ii;
          wr = 1'b1;
          val = mdm[addr[7:2]];
        end
        OP_STORE: if (f3 == 3'd2) begin
          addr = a + is;
          mdm[addr[7:2]] = b;
        end
        default: ;
      endcase
      if (wr && ins[11:7] != 5'd0) r[ins[11:7]] = val;
      p = npc;
      steps++;
    end
  endtask

  function automatic logic [4:0] pick_src(input logic [4:0] l1, input logic [4:0] l2);
    logic [4:0] s;
    s = 5'($urandom_range(0, 7));
    while (s != 5'd0 && (s == l1 || s == l2)) s = 5'($urandom_range(0, 7));
    return s;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    for (int i = 0; i < 64; i++) dmem_init[i] = 32'd0;
  endtask

  // Sources never read a register written by either of the two preceding program slots.
  task automatic build_random(output int plen);
    logic [4:0]  rd, s1, s2, l1, l2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        wrote;
    int          idx, kind, sel;
    logic [2:0]  bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    clear_mem();
    for (int i = 0; i < 64; i++) dmem_init[i] = $urandom;
    idx = 0;
    for (int r = 1; r < 8; r++) begin
      imem[idx] = enc_i(OP_IMM, FUNCT3_ADD, 5'(r), 5'd0, $urandom_range(0, 4095));
      idx++;
    end
    idx += 2;
    l1 = 5'd0;
    l2 = 5'd0;
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 9);
      rd = 5'($urandom_range(0, 7));
      s1 = pick_src(l1, l2);
      s2 = pick_src(l1, l2);
      f3 = 3'($urandom_range(0, 7));
      wrote = 1'b1;
      case (kind)
        0: begin
          if (f3 == 3'd1) imm = $urandom_range(0, 31);
          else if (f3 == 3'd5) imm = $urandom_range(0, 31) | ($urandom_range(0, 1) != 0 ? 32'h400 : 32'h0);
          else imm = $urandom_range(0, 4095);
          imem[idx] = enc_i(OP_IMM, f3, rd, s1, imm);
        end
        1, 2: begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
          imem[idx] = enc_r(f7, f3, rd, s1, s2);
        end
        3: imem[idx] = enc_u(OP_LUI, rd, $urandom);
        4: imem[idx] = enc_u(OP_AUIPC, rd, $urandom);
        5: imem[idx] = enc_i(OP_LOAD, FUNCT3_LW, rd, 5'd0, 4 * $urandom_range(0, 15));
        6: begin
          imem[idx] = enc_s(FUNCT3_SW, 5'd0, s2, 4 * (16 + $urandom_range(0, 15)));
          wrote = 1'b0;
        end
        7: begin
          imem[idx] = enc_b(bf[$urandom_range(0, 5)], s1, s2, ($urandom_range(0, 1) != 0) ? 32'd8 : 32'd12);
          wrote = 1'b0;
        end
        8: begin
          if ($urandom_range(0, 1) != 0) imem[idx] = enc_j(rd, 32'd8);
          else imem[idx] = enc_i(OP_JALR, 3'd0, rd, 5'd0, 32'(4 * (idx + 2) + $urandom_range(0, 1)));
        end
        default: begin
          wrote = 1'b0;
          sel = $urandom_range(0, 4);
          case (sel)
            0: imem[idx] = enc_i(OP_LOAD, 3'd0, rd, 5'd0, 32'd4);
            1: imem[idx] = enc_s(3'd0, 5'd0, s2, 32'd0);
            2: imem[idx] = 32'h0000000F;
            3: imem[idx] = 32'h00000073;
            default: imem[idx] = {25'h1abcd, 7'h0B} ^ {20'h0, rd, 7'h0};
          endcase
        end
      endcase
      l2 = l1;
      l1 = wrote ? rd : 5'd0;
      idx++;
    end
    idx += 2;
    for (int r = 1; r < 8; r++) begin
      imem[idx] = enc_s(FUNCT3_SW, 5'd0, 5'(r), 32'(160 + 4 * (r - 1)));
      idx++;
    end
    plen = idx;
  endtask

  task automatic start_run();
    rst = 1'b0;
    mem_init = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
    check("rst_pc", pc, 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int plen;
    #1;
    check("init_pc", pc, 32'd0);
    check("init_mem_write", 32'(mem_write), 32'd0);

    // two stores separated from their producers by zero words
    clear_mem();
    imem[0] = enc_i(OP_IMM, FUNCT3_ADD, 5'd5, 5'd0, 32'd42);
    imem[1] = enc_i(OP_IMM, FUNCT3_ADD, 5'd1, 5'd0, 32'd77);
    imem[5] = enc_s(FUNCT3_SW, 5'd0, 5'd5, 32'd12);
    imem[6] = enc_s(FUNCT3_SW, 5'd0, 5'd1, 32'd8);
    start_run();
    repeat (10) @(posedge clk);
    #1 check("sw_word3", dmem[3], 32'd42);
    @(posedge clk);
    #1 check("sw_word2", dmem[2], 32'd77);

    // all-zero stream: pc steps by 4, no stores
    clear_mem();
    start_run();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      check("zero_pc", pc, 32'(4 * i));
      check("zero_mem_write", 32'(mem_write), 32'd0);
    end

    // load then store through a register
    clear_mem();
    dmem_init[4] = 32'h1234;
    imem[0] = enc_i(OP_LOAD, FUNCT3_LW, 5'd2, 5'd0, 32'd16);
    imem[2] = enc_s(FUNCT3_SW, 5'd0, 5'd2, 32'd20);
    start_run();
    repeat (10) @(posedge clk);
    #1 check("lw_sw_word5", dmem[5], 32'h1234);

    // taken branch squashes the next store
    clear_mem();
    dmem_init[0] = 32'hAAAA5555;
    imem[0] = enc_b(FUNCT3_BEQ, 5'd0, 5'd0, 32'd8);
    imem[1] = enc_s(FUNCT3_SW, 5'd0, 5'd0, 32'd0);
    imem[2] = enc_i(OP_IMM, FUNCT3_ADD, 5'd4, 5'd0, 32'd9);
    imem[4] = enc_s(FUNCT3_SW, 5'd0, 5'd4, 32'd4);
    start_run();
    repeat (2) @(posedge clk);
    #1 check("br_pc_target", pc, 32'd8);
    repeat (10) @(posedge clk);
    #1 check("br_squash_word0", dmem[0], 32'hAAAA5555);
    check("br_target_word1", dmem[1], 32'd9);

    // x0 stays zero, negative immediate sign-extends
    clear_mem();
    dmem_init[0] = 32'h5A5A;
    imem[0] = enc_i(OP_IMM, FUNCT3_ADD, 5'd0, 5'd0, 32'd5);
    imem[2] = enc_i(OP_IMM, FUNCT3_ADD, 5'd3, 5'd0, 32'hFFFFFFFF);
    imem[3] = enc_s(FUNCT3_SW, 5'd0, 5'd0, 32'd0);
    imem[4] = enc_s(FUNCT3_SW, 5'd0, 5'd3, 32'd4);
    start_run();
    repeat (10) @(posedge clk);
    #1 check("x0_word0", dmem[0], 32'd0);
    check("neg_word1", dmem[1], 32'hFFFFFFFF);

    // asynchronous reset while a store is in MEM
    clear_mem();
    imem[0] = enc_i(OP_IMM, FUNCT3_ADD, 5'd6, 5'd0, 32'd33);
    imem[2] = enc_s(FUNCT3_SW, 5'd0, 5'd6, 32'd24);
    start_run();
    repeat (4) @(posedge clk);
    #1 check("pre_rst_mem_write", 32'(mem_write), 32'd1);
    #1 rst = 1'b0;
    #1 check("async_rst_pc", pc, 32'd0);
    check("async_rst_mem_write", 32'(mem_write), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("no_partial_store", dmem[6], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("restart_pc", pc, 32'd4);
    repeat (7) @(posedge clk);
    #1 check("restart_store", dmem[6], 32'd33);

    // random programs against the ISA model
    for (int t = 0; t < 25; t++) begin
      build_random(plen);
      run_model(plen);
      start_run();
      repeat (plen + 12) @(posedge clk);
      #1;
      for (int w = 0; w < 64; w++) check($sformatf("rand%0d_word%0d", t, w), dmem[w], mdm[w]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
